inst_fetch_queue: RTL and testbench
===================================

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/PC width.
REQ-002 SHALL have parameter DEPTH, default 4, fetch-queue entries; power of two, >=2.
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address.
REQ-004 SHALL have port clk_in  in  1  the single clock.
REQ-005 SHALL have port rst_in  in  1  reset; asynchronous, active-low.
REQ-006 SHALL have port rdy_in  in  1  global enable; low freezes all state.
REQ-007 SHALL have port _mem_req  out  1  instruction-fetch request pending.
REQ-008 SHALL have port _mem_addr  out  XLEN  fetch address; stable while _mem_req high.
REQ-009 SHALL have port _inst_ready_in  in  1  memory returns the instruction this cycle.
REQ-010 SHALL have port _inst_in  in  32  returned instruction word.
REQ-011 SHALL have port _br_rob  in  1  ROB redirect (mispredict/flush).
REQ-012 SHALL have port _rob_new_pc  in  XLEN  redirect target.
REQ-013 SHALL have port _deq  in  1  decoder consumes head entry.
REQ-014 SHALL have port _out_valid  out  1  queue non-empty.
REQ-015 SHALL have port _out_inst  out  32  head instruction.
REQ-016 SHALL have port _out_pc  out  XLEN  head instruction address.
REQ-017 SHALL have port _out_pred_taken  out  1  head was predicted taken.
REQ-018 SHALL have port _count  out  $clog2(DEPTH)+1  current occupancy.

Function
REQ-019 SHALL run FSM IDLE / WAIT / DISCARD; _mem_req = (state==WAIT), registered.
REQ-020 IDLE->WAIT SHALL occur when _count<DEPTH and no _br_rob; _mem_addr <= pc.
REQ-021 In WAIT, _inst_ready_in SHALL enqueue {_inst_in, pc, pred}, advance pc, return to IDLE; minimum 2 cycles per fetch.
REQ-022 Next pc SHALL be pc+4 modulo 2^XLEN (wrap, no flag).
REQ-023 _out_valid/_out_inst/_out_pc/_out_pred_taken SHALL be combinational from the head entry; zero when empty.
REQ-024 _deq while empty SHALL be ignored; simultaneous enqueue+dequeue SHALL leave _count unchanged.
REQ-025 At most one request SHALL be outstanding; slot availability is checked only at issue.
REQ-026 _br_rob SHALL flush the queue (_count=0), set pc <= _rob_new_pc, and override same-cycle enqueue/dequeue.
REQ-027 _br_rob in WAIT without same-cycle ack SHALL go to DISCARD; with same-cycle ack the word SHALL be dropped and state -> IDLE.
REQ-028 In DISCARD, _mem_req SHALL stay high at the old address; the ack SHALL be dropped, then -> IDLE.
REQ-029 _br_rob in DISCARD SHALL update pc only and stay in DISCARD.
REQ-030 _inst_ready_in outside WAIT/DISCARD SHALL be ignored.
REQ-031 rdy_in low SHALL hold every register, including pointers, pc and state; inputs are ignored.

Reset
REQ-032 rst_in low SHALL asynchronously set state=IDLE, pc=RESET_PC, pointers and _count=0, _mem_req=0, _mem_addr=0.
REQ-033 Reset mid-WAIT SHALL abandon the request; a late ack SHALL be ignored.

Configuration
REQ-034 Macro IFQ_JAL_PREDICT_EN defined: enqueued JAL (opcode 1101111) SHALL set pc <= pc + sext(J-imm) and pred=1.
REQ-035 Macro absent: pc SHALL always advance by 4 and _out_pred_taken SHALL tie to 0.

Structure
REQ-036 Package ifq_pkg SHALL hold the FSM state encoding, the JAL opcode constant and the entry layout (inst, pc, pred).
REQ-037 Storage SHALL be sub-module ifq_fifo (parametrised DEPTH/width circular buffer with head/tail/count).

Verification
REQ-038 Reset, ack every 2nd cycle, no _deq -> addresses 0,4,8,12 fetched; _count=4; _mem_req stays 0.
REQ-039 Full (DEPTH=4) plus one _deq -> exactly one new fetch at 16; _count returns to 4.
REQ-040 _br_rob to 0x100 in WAIT, ack 3 cycles later -> word dropped, _count=0, next _mem_addr=0x100.
REQ-041 _br_rob with same-cycle ack and _deq -> queue empty, state IDLE, pc=_rob_new_pc.
REQ-042 IFQ_JAL_PREDICT_EN, JAL +0x20 at 0x8 -> next _mem_addr=0x28, _out_pred_taken=1; without the macro -> 0xC, pred 0.
REQ-043 rdy_in low for 5 cycles mid-WAIT with ack pulses -> no state change; pc=0xFFFFFFFC wraps to 0.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared definitions for the instruction fetch queue: FSM encoding, JAL decode
// and the layout of a queue entry {inst, pc, pred}.
package ifq_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    localparam logic [6:0] OPC_JAL = 7'b1101111;

    // Entry packs as {inst, pc, pred} with pred in the LSB
    localparam int ENT_INST_W   = 32;
    localparam int ENT_PRED_LSB = 0;
    localparam int ENT_PC_LSB   = 1;

    function automatic int ent_width(input int xlen);
        return ENT_INST_W + xlen + 1;
    endfunction

    // J-type immediate from instruction bits [31:12]
    function automatic logic signed [20:0] jal_imm(input logic [31:12] ib);
        return {ib[31], ib[19:12], ib[20], ib[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Circular buffer with head/tail pointers and occupancy count; flush clears
// pointers and count, and a pop on an empty buffer is ignored.
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_push = en && !flush && push && (count != CNT_W'(DEPTH));
    assign do_pop  = en && !flush && pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (en && flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + PTR_W'(1);
            if (do_pop)  head <= head + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[tail] <= wdata;
    end

    assign rdata = mem[head];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch FSM feeding a small queue of {inst, pc, pred} entries.
// Define IFQ_JAL_PREDICT_EN to redirect the fetch PC on enqueued JALs.
module inst_fetch_queue
    import ifq_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    output logic                    _mem_req,
    output logic [XLEN-1:0]         _mem_addr,
    input  logic                    _inst_ready_in,
    input  logic [31:0]             _inst_in,
    input  logic                    _br_rob,
    input  logic [XLEN-1:0]         _rob_new_pc,
    input  logic                    _deq,
    output logic                    _out_valid,
    output logic [31:0]             _out_inst,
    output logic [XLEN-1:0]         _out_pc,
    output logic                    _out_pred_taken,
    output logic [$clog2(DEPTH):0]  _count
);
    localparam int CNT_W    = $clog2(DEPTH) + 1;
    localparam int ENT_W    = ent_width(XLEN);
    localparam int INST_LSB = ENT_PC_LSB + XLEN;

    logic [1:0]       state;
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  pc_next;
    logic             pred;
    logic             enq;
    logic             q_empty;
    logic [ENT_W-1:0] wr_entry;
    logic [ENT_W-1:0] head_entry;

    always_comb begin
        pred    = 1'b0;
        pc_next = pc + XLEN'(4);
`ifdef IFQ_JAL_PREDICT_EN
        if (_inst_in[6:0] == OPC_JAL) begin
            pred    = 1'b1;
            pc_next = pc + XLEN'(jal_imm(_inst_in[31:12]));
        end
`endif
    end

    // A redirect always wins over a same-cycle ack, so the word is never queued
    assign enq      = rdy_in && (state == ST_WAIT) && _inst_ready_in && !_br_rob;
    assign wr_entry = {_inst_in, pc, pred};

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            _mem_req  <= 1'b0;
            _mem_addr <= '0;
        end else if (rdy_in) begin
            case (state)
                ST_IDLE: begin
                    if (_br_rob) begin
                        pc <= _rob_new_pc;
                    end else if (_count < CNT_W'(DEPTH)) begin
                        state     <= ST_WAIT;
                        _mem_req  <= 1'b1;
                        _mem_addr <= pc;
                    end
                end
                ST_WAIT: begin
                    if (_br_rob) begin
                        pc <= _rob_new_pc;
                        if (_inst_ready_in) begin
                            state    <= ST_IDLE;
                            _mem_req <= 1'b0;
                        end else begin
                            state <= ST_DISCARD;
                        end
                    end else if (_inst_ready_in) begin
                        pc       <= pc_next;
                        state    <= ST_IDLE;
                        _mem_req <= 1'b0;
                    end
                end
                ST_DISCARD: begin
                    // Keep the stale request asserted until memory answers it
                    if (_br_rob) pc <= _rob_new_pc;
                    if (_inst_ready_in) begin
                        state    <= ST_IDLE;
                        _mem_req <= 1'b0;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    _mem_req <= 1'b0;
                end
            endcase
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk   (clk_in),
        .rst_n (rst_in),
        .en    (rdy_in),
        .flush (_br_rob),
        .push  (enq),
        .pop   (_deq),
        .wdata (wr_entry),
        .rdata (head_entry),
        .count (_count),
        .empty (q_empty)
    );

    // Head fields read as zero while the queue is empty
    assign _out_valid      = !q_empty;
    assign _out_inst       = q_empty ? '0 : head_entry[ENT_W-1:INST_LSB];
    assign _out_pc         = q_empty ? '0 : head_entry[INST_LSB-1:ENT_PC_LSB];
    assign _out_pred_taken = q_empty ? 1'b0 : head_entry[ENT_PRED_LSB];

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue (XLEN=32, DEPTH=4, RESET_PC=0).
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy = 1'b1;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        ack = 1'b0;
    logic [31:0] inst = '0;
    logic        br = 1'b0;
    logic [31:0] new_pc = '0;
    logic        deq = 1'b0;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_pred;
    logic [2:0]  count;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [31:0] addr;
    logic [31:0] exp_next;
    logic        exp_pred;

    always #5 clk = ~clk;

    inst_fetch_queue #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk_in          (clk),
        .rst_in          (rst_n),
        .rdy_in          (rdy),
        ._mem_req        (mem_req),
        ._mem_addr       (mem_addr),
        ._inst_ready_in  (ack),
        ._inst_in        (inst),
        ._br_rob         (br),
        ._rob_new_pc     (new_pc),
        ._deq            (deq),
        ._out_valid      (out_valid),
        ._out_inst       (out_inst),
        ._out_pc         (out_pc),
        ._out_pred_taken (out_pred),
        ._count          (count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a request, then acknowledge it for one cycle
    task automatic serve(input logic [31:0] word, output logic [31:0] a);
        int n = 0;
        while (!mem_req && n < 8) begin
            step();
            n++;
        end
        chk("req_seen", mem_req, 1);
        a    = mem_addr;
        ack  = 1'b1;
        inst = word;
        step();
        ack  = 1'b0;
    endtask

    initial begin
`ifdef IFQ_JAL_PREDICT_EN
        exp_next = 32'h28;
        exp_pred = 1'b1;
`else
        exp_next = 32'hC;
        exp_pred = 1'b0;
`endif
        step();
        step();
        chk("rst_req", mem_req, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_count", count, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_inst", out_inst, 0);
        chk("rst_pc", out_pc, 0);

        // Dequeue on an empty queue is ignored while the first fetch issues
        rst_n = 1'b1;
        deq   = 1'b1;
        step();
        deq   = 1'b0;
        chk("deq_empty_cnt", count, 0);
        chk("first_req", mem_req, 1);
        chk("first_addr", mem_addr, 0);

        // Fill the queue: 0, 4, 8, 12
        for (int i = 0; i < 4; i++) begin
            serve(32'h13 | (i << 12), addr);
            chk("fill_addr", addr, i * 4);
        end
        chk("full_count", count, 4);
        chk("full_valid", out_valid, 1);
        chk("full_head_pc", out_pc, 0);
        chk("full_head_inst", out_inst, 32'h13);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("full_no_req", mem_req, 0);
        end

        // One dequeue frees one slot -> exactly one fetch at 16
        deq = 1'b1;
        step();
        deq = 1'b0;
        chk("deq_count", count, 3);
        chk("deq_head_pc", out_pc, 4);
        chk("deq_head_inst", out_inst, 32'h1013);
        serve(32'h5013, addr);
        chk("refill_addr", addr, 16);
        chk("refill_count", count, 4);
        step();
        step();
        chk("refill_no_req", mem_req, 0);

        // Redirect in WAIT without ack -> DISCARD, late ack dropped
        deq = 1'b1;
        step();
        deq = 1'b0;
        step();
        chk("wait20_req", mem_req, 1);
        chk("wait20_addr", mem_addr, 20);
        br     = 1'b1;
        new_pc = 32'h100;
        step();
        br     = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_valid", out_valid, 0);
        chk("discard_req", mem_req, 1);
        chk("discard_addr", mem_addr, 20);
        step();
        step();
        chk("discard_hold", mem_req, 1);
        ack  = 1'b1;
        inst = 32'h6013;
        step();
        ack  = 1'b0;
        chk("drop_count", count, 0);
        chk("drop_req", mem_req, 0);
        step();
        chk("redir_req", mem_req, 1);
        chk("redir_addr", mem_addr, 32'h100);
        serve(32'h7013, addr);
        chk("redir_count", count, 1);
        chk("redir_head_pc", out_pc, 32'h100);
        chk("redir_head_inst", out_inst, 32'h7013);

        // Simultaneous enqueue and dequeue keeps the count
        step();
        chk("sim_addr", mem_addr, 32'h104);
        ack  = 1'b1;
        inst = 32'h8013;
        deq  = 1'b1;
        step();
        ack  = 1'b0;
        deq  = 1'b0;
        chk("sim_count", count, 1);
        chk("sim_head_pc", out_pc, 32'h104);
        chk("sim_head_inst", out_inst, 32'h8013);

        // Redirect with same-cycle ack and dequeue
        step();
        chk("w108_addr", mem_addr, 32'h108);
        br     = 1'b1;
        new_pc = 32'h200;
        ack    = 1'b1;
        inst   = 32'h9013;
        deq    = 1'b1;
        step();
        br  = 1'b0;
        ack = 1'b0;
        deq = 1'b0;
        chk("br_ack_count", count, 0);
        chk("br_ack_valid", out_valid, 0);
        chk("br_ack_req", mem_req, 0);
        step();
        chk("br_ack_next_req", mem_req, 1);
        chk("br_ack_next_addr", mem_addr, 32'h200);

        // JAL +0x20 at 0x8
        br     = 1'b1;
        new_pc = 32'h8;
        ack    = 1'b1;
        inst   = 32'h13;
        step();
        br  = 1'b0;
        ack = 1'b0;
        step();
        chk("jal_fetch_addr", mem_addr, 32'h8);
        serve(32'h020000EF, addr);
        chk("jal_count", count, 1);
        chk("jal_head_pc", out_pc, 32'h8);
        chk("jal_head_inst", out_inst, 32'h020000EF);
        chk("jal_pred", out_pred, exp_pred);
        step();
        chk("jal_next_req", mem_req, 1);
        chk("jal_next_addr", mem_addr, exp_next);

        // rdy low freezes everything mid-WAIT
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ack    = i[0];
            inst   = 32'hC013;
            deq    = 1'b1;
            br     = (i == 2);
            new_pc = 32'h400;
            step();
        end
        rdy = 1'b1;
        ack = 1'b0;
        deq = 1'b0;
        br  = 1'b0;
        chk("frz_req", mem_req, 1);
        chk("frz_addr", mem_addr, exp_next);
        chk("frz_count", count, 1);
        chk("frz_head_pc", out_pc, 32'h8);
        serve(32'hA013, addr);
        chk("frz_serve_addr", addr, exp_next);
        chk("frz_serve_count", count, 2);
        step();
        chk("frz_pc_next", mem_addr, exp_next + 32'h4);

        // Redirects while in DISCARD only move pc; then wrap at the top
        br     = 1'b1;
        new_pc = 32'h300;
        step();
        new_pc = 32'hFFFF_FFFC;
        step();
        br = 1'b0;
        chk("disc2_req", mem_req, 1);
        chk("disc2_addr", mem_addr, exp_next + 32'h4);
        chk("disc2_count", count, 0);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("disc2_done", mem_req, 0);
        serve(32'hB013, addr);
        chk("top_addr", addr, 32'hFFFF_FFFC);
        chk("top_head_pc", out_pc, 32'hFFFF_FFFC);
        step();
        chk("wrap_req", mem_req, 1);
        chk("wrap_addr", mem_addr, 32'h0);

        // Asynchronous reset mid-WAIT, late ack ignored
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", mem_req, 0);
        chk("arst_count", count, 0);
        ack  = 1'b1;
        inst = 32'hD013;
        #2 rst_n = 1'b1;
        step();
        chk("late_ack_count", count, 0);
        chk("late_ack_req", mem_req, 1);
        chk("late_ack_addr", mem_addr, 32'h0);
        ack = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
